// File: rtl/dcache_ctrl.sv
// Direct-mapped write-through L1 data cache controller (no-write-allocate) for the MEM stage.
// Load hit: 0 cycles; load miss: 1 + WORDS beats, then DONE; store: 2 cycles, then DONE.
// mem_ready low stretches stall_cache one cycle per wait; DCACHE_STATS_EN adds hit/miss counters.
module dcache_ctrl #(
  parameter int LINES = 16,
  parameter int WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_wstrb,
  output logic [31:0] cpu_rdata,
  output logic        stall_cache,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int IDX_W = $clog2(LINES);
  localparam int OFF_W = $clog2(WORDS);
  localparam int TAG_W = 30 - IDX_W - OFF_W;

  typedef enum logic [1:0] {S_IDLE, S_REFILL, S_WRITE, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [OFF_W-1:0]   beat_q, beat_d;
  logic [LINES-1:0]   valid_q;
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [31:0]        data_q [LINES][WORDS];

  logic [OFF_W-1:0]   offset;
  logic [IDX_W-1:0]   index;
  logic [TAG_W-1:0]   tag;
  logic               hit;
  logic               refill_wr;
  logic               store_wr;
  logic [31:0]        merged;
  logic               unused_addr_bits;

  assign offset = cpu_addr[OFF_W+1:2];
  assign index  = cpu_addr[OFF_W+IDX_W+1:OFF_W+2];
  assign tag    = cpu_addr[31:OFF_W+IDX_W+2];
  assign hit    = valid_q[index] && (tag_q[index] == tag);
  // Byte lane bits never index the array; they only matter to the memory side via wstrb.
  assign unused_addr_bits = ^cpu_addr[1:0];

  // Invalid lines read as zero so stale refill fragments are never visible.
  assign cpu_rdata = valid_q[index] ? data_q[index][offset] : 32'h0;

  // Store data merged byte-wise into the resident word.
  always_comb begin
    merged = data_q[index][offset];
    for (int b = 0; b < 4; b++) begin
      if (cpu_wstrb[b]) merged[b*8 +: 8] = cpu_wdata[b*8 +: 8];
    end
  end

  // Next-state and output decode; cpu inputs are held stable by the pipeline while stalled.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    stall_cache = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = 32'h0;
    mem_wdata   = 32'h0;
    mem_wstrb   = 4'h0;
    refill_wr   = 1'b0;
    store_wr    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cpu_req) begin
          if (cpu_we) begin
            stall_cache = 1'b1;
            state_d     = S_WRITE;
          end else if (!hit) begin
            stall_cache = 1'b1;
            state_d     = S_REFILL;
            beat_d      = '0;
          end
        end
      end
      S_REFILL: begin
        stall_cache = 1'b1;
        mem_req     = 1'b1;
        mem_addr    = {tag, index, beat_q, 2'b00};
        if (mem_ready) begin
          refill_wr = 1'b1;
          beat_d    = beat_q + 1'b1;
          if (&beat_q) state_d = S_DONE;
        end
      end
      S_WRITE: begin
        stall_cache = 1'b1;
        mem_req     = 1'b1;
        mem_we      = 1'b1;
        mem_addr    = {cpu_addr[31:2], 2'b00};
        mem_wdata   = cpu_wdata;
        mem_wstrb   = cpu_wstrb;
        if (mem_ready) begin
          store_wr = hit;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        // One-cycle release so a store still on the inputs is not issued twice.
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state; valid is set only with the final refill beat so a cut-short refill stays invalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      if (refill_wr && (&beat_q)) valid_q[index] <= 1'b1;
    end
  end

  // Tag and data arrays; writes are suppressed during reset so in-flight beats are dropped.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (refill_wr) data_q[index][beat_q] <= mem_rdata;
      if (refill_wr && (&beat_q)) tag_q[index] <= tag;
      if (store_wr) data_q[index][offset] <= merged;
    end
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  // Load hit/miss counters sampled in IDLE only; stores are not counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= 32'h0;
      miss_cnt_q <= 32'h0;
    end else if (state_q == S_IDLE && cpu_req && !cpu_we) begin
      if (hit) hit_cnt_q  <= hit_cnt_q + 32'h1;
      else     miss_cnt_q <= miss_cnt_q + 32'h1;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: directed scenarios then randomized loads/stores against a memory/residency model.
// Model predicts stall counts, beat addresses and load data from the cache rules.
// Memory side randomly withholds mem_ready to exercise wait cycles.
module tb_dcache_ctrl;

  localparam int WORDS = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [3:0]  cpu_wstrb;
  logic [31:0] cpu_rdata;
  logic        stall_cache;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ready;
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  dcache_ctrl #(.LINES(16), .WORDS(WORDS)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb), .cpu_rdata(cpu_rdata),
    .stall_cache(stall_cache),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
`ifdef DCACHE_STATS_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Backing memory contents (sparse) and which line tag is resident per index.
  logic [31:0] mem_m [logic [31:0]];
  logic [23:0] rtag [16];
  bit   [15:0] rvalid;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_m.exists(a)) return mem_m[a];
    return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
  endfunction

  function automatic void mem_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] w;
    w = mem_rd(a);
    for (int b = 0; b < 4; b++) if (s[b]) w[b*8 +: 8] = d[b*8 +: 8];
    mem_m[a] = w;
  endfunction

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1; cpu_req = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    rvalid = '0;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    cpu_req = 1'b0; mem_ready = 1'b0;
    #1;
    check("idle_stall", 32'(stall_cache), 32'h0);
    check("idle_req", 32'(mem_req), 32'h0);
    check("idle_addr", mem_addr, 32'h0);
  endtask

  // One CPU access, acting as memory until the controller releases the stall.
  // Returns at #1 into the release cycle (DONE or zero-stall hit).
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] ws, input int hold_beat, input int hold_len,
                        input bit rnd_ready);
    int idx, exp_beats, beats, waits, stalls, held;
    bit hit, done;
    logic [31:0] exp_addr;
    idx = int'(addr[7:4]);
    hit = !we && rvalid[idx] && (rtag[idx] == addr[31:8]);
    exp_beats = we ? 1 : (hit ? 0 : WORDS);
    beats = 0; waits = 0; stalls = 0; held = 0; done = 1'b0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cpu_wstrb = ws;
    mem_ready = 1'b0;
    for (int cyc = 0; cyc < 100 && !done; cyc++) begin
      #1;
      if (!stall_cache) begin
        done = 1'b1;
      end else begin
        stalls++;
        mem_ready = 1'b0;
        mem_rdata = $urandom;
        if (cyc == 0) check("detect_req", 32'(mem_req), 32'h0);
        if (mem_req) begin
          exp_addr = we ? {addr[31:2], 2'b00} : {addr[31:4], 2'(beats), 2'b00};
          check("mem_addr", mem_addr, exp_addr);
          check("mem_we", 32'(mem_we), 32'(we));
          if (we) begin
            check("mem_wdata", mem_wdata, wd);
            check("mem_wstrb", 32'(mem_wstrb), 32'(ws));
          end
          mem_ready = 1'b1;
          if (beats == hold_beat && held < hold_len) begin
            mem_ready = 1'b0;
            held++;
          end else if (rnd_ready && $urandom_range(0, 3) == 0) begin
            mem_ready = 1'b0;
          end
          if (mem_ready) begin
            if (we) mem_wr(exp_addr, wd, ws);
            else    mem_rdata = mem_rd(exp_addr);
            beats++;
          end else begin
            waits++;
          end
        end
        @(negedge clk);
        mem_ready = 1'b0;
      end
    end
    if (!done) check("timeout", 32'(stall_cache), 32'h0);
    check("stalls", 32'(stalls), hit ? 32'h0 : 32'(1 + exp_beats + waits));
    check("beats", 32'(beats), 32'(exp_beats));
    check("rel_req", 32'(mem_req), 32'h0);
    if (!we) begin
      check("rdata", cpu_rdata, mem_rd({addr[31:2], 2'b00}));
      if (!hit) begin
        rvalid[idx] = 1'b1;
        rtag[idx]   = addr[31:8];
      end
    end
  endtask

  initial begin
    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h104;
    cpu_wdata = 32'h0; cpu_wstrb = 4'h0; mem_rdata = 32'h0; mem_ready = 1'b0;
    rvalid = '0;
    mem_m[32'h100] = 32'hA0; mem_m[32'h104] = 32'hA1;
    mem_m[32'h108] = 32'hA2; mem_m[32'h10C] = 32'hA3;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_stall", 32'(stall_cache), 32'h0);
    check("rst_req", 32'(mem_req), 32'h0);
    check("rst_we", 32'(mem_we), 32'h0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_wdata", mem_wdata, 32'h0);
    check("rst_wstrb", 32'(mem_wstrb), 32'h0);
    check("rst_rdata", cpu_rdata, 32'h0);

    // Miss refill, then a hit to the same line.
    access(1'b0, 32'h104, 32'h0, 4'h0, -1, 0, 1'b0);
    check("miss_data", cpu_rdata, 32'hA1);
    access(1'b0, 32'h108, 32'h0, 4'h0, -1, 0, 1'b0);
    check("hit_data", cpu_rdata, 32'hA2);

    // Store hit merges the low two bytes, then read back.
    access(1'b1, 32'h104, 32'hDEADBEEF, 4'b0011, -1, 0, 1'b0);
    access(1'b0, 32'h104, 32'h0, 4'h0, -1, 0, 1'b0);
    check("merge_data", cpu_rdata, 32'h0000BEEF);

    // Store miss does not allocate.
    access(1'b1, 32'h1000, 32'h1234_5678, 4'hF, -1, 0, 1'b0);
    access(1'b0, 32'h1000, 32'h0, 4'h0, -1, 0, 1'b0);
    idle_cycle();

    // Three wait cycles on beat 2 of a refill.
    reset_dut();
    access(1'b0, 32'h104, 32'h0, 4'h0, 2, 3, 1'b0);

    // Reset after beat 1 of a refill: line stays invalid, re-issue refills from beat 0.
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h304; mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      mem_rdata = mem_rd(mem_addr);
      @(negedge clk);
    end
    #1;
    check("cut_addr", mem_addr, 32'h308);
    rst = 1'b1; cpu_req = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0; mem_ready = 1'b0; rvalid = '0;
    #1;
    check("cut_stall", 32'(stall_cache), 32'h0);
    check("cut_req", 32'(mem_req), 32'h0);
    check("cut_rdata", cpu_rdata, 32'h0);
    access(1'b0, 32'h304, 32'h0, 4'h0, -1, 0, 1'b0);

    // Randomized mix over a few tags so hits, misses and evictions all occur.
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      a = {22'h0, 2'($urandom_range(0, 3)), 4'($urandom), 2'($urandom), 2'b00};
      if ($urandom_range(0, 3) == 0)
        access(1'b1, a, $urandom, 4'($urandom), -1, 0, 1'b1);
      else
        access(1'b0, a, 32'h0, 4'h0, -1, 0, 1'b1);
      if ($urandom_range(0, 4) == 0) idle_cycle();
    end

    idle_cycle();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_err, n_chk);
    $fatal(1);
  end

endmodule
